// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : iterative_alu
// Brief    : Execute-stage ALU. Arithmetic, logic and compare ops produce a
//            registered result one cycle after acceptance; shifts run serially,
//            one bit per cycle, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_alu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_alu_control,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    output logic            o_valid,
    input  logic            i_result_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam logic [4:0] C_OP_ADD  = 5'b00000;
    localparam logic [4:0] C_OP_AND  = 5'b00001;
    localparam logic [4:0] C_OP_OR   = 5'b00010;
    localparam logic [4:0] C_OP_XOR  = 5'b00011;
    localparam logic [4:0] C_OP_SLL  = 5'b00100;
    localparam logic [4:0] C_OP_SRL  = 5'b00101;
    localparam logic [4:0] C_OP_SRA  = 5'b00110;
    localparam logic [4:0] C_OP_SUB  = 5'b10000;
    localparam logic [4:0] C_OP_SLTU = 5'b11000;
    localparam logic [4:0] C_OP_SLT  = 5'b10111;

    // Shift kind is kept as the low two bits of the control code:
    // 00 = SLL, 01 = SRL, 10 = SRA.
    localparam logic [1:0] C_SH_SLL = 2'b00;
    localparam logic [1:0] C_SH_SRL = 2'b01;

    localparam logic [SHAMT_W-1:0] C_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_q;
    logic               valid_q;
    logic               ready_q;
    logic [XLEN-1:0]    result_q;
    logic               zero_q;
    logic [XLEN-1:0]    shreg_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [1:0]         sh_op_q;

    logic [XLEN-1:0]    alu_d;
    logic [XLEN-1:0]    shreg_d;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;

    assign shamt    = i_operand_b[SHAMT_W-1:0];
    assign is_shift = (i_alu_control == C_OP_SLL) ||
                      (i_alu_control == C_OP_SRL) ||
                      (i_alu_control == C_OP_SRA);

    // Single-cycle result for every non-shift code; unknown codes fall back to ADD.
    always_comb begin
        alu_d = i_operand_a + i_operand_b;
        case (i_alu_control)
            C_OP_AND:  alu_d = i_operand_a & i_operand_b;
            C_OP_OR:   alu_d = i_operand_a | i_operand_b;
            C_OP_XOR:  alu_d = i_operand_a ^ i_operand_b;
            C_OP_SUB:  alu_d = i_operand_a - i_operand_b;
            C_OP_SLTU: alu_d = {{(XLEN-1){1'b0}}, (i_operand_a < i_operand_b)};
            C_OP_SLT:  alu_d = {{(XLEN-1){1'b0}},
                                ($signed(i_operand_a) < $signed(i_operand_b))};
            default:   alu_d = i_operand_a + i_operand_b;
        endcase
    end

    // One-bit step of the serial shifter; SRA keeps the MSB, which is the
    // original operand sign because it is never overwritten.
    always_comb begin
        shreg_d = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
        case (sh_op_q)
            C_SH_SLL: shreg_d = {shreg_q[XLEN-2:0], 1'b0};
            C_SH_SRL: shreg_d = {1'b0, shreg_q[XLEN-1:1]};
            default:  shreg_d = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b1;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sh_op_q  <= C_SH_SLL;
        end else if (i_flush) begin
            // Abort: the held result stays in o_result but is never delivered.
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (!is_shift) begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            valid_q  <= 1'b1;
                            state_q  <= ST_RESP;
                        end else if (shamt == '0) begin
                            result_q <= i_operand_a;
                            zero_q   <= (i_operand_a == '0);
                            valid_q  <= 1'b1;
                            state_q  <= ST_RESP;
                        end else begin
                            shreg_q <= i_operand_a;
                            cnt_q   <= shamt;
                            sh_op_q <= i_alu_control[1:0];
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // The last step writes straight into the result register so
                    // o_valid rises shamt+1 cycles after acceptance.
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE) begin
                        result_q <= shreg_d;
                        zero_q   <= (shreg_d == '0);
                        valid_q  <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_result_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_valid  = valid_q;
    assign o_ready  = ready_q;
    assign o_result = result_q;
    assign o_zero   = zero_q;

endmodule
`default_nettype wire

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Execute-stage ALU sitting directly downstream of the ALU control decoder; consumes its 5-bit ALU control code plus two operands.
- Single-cycle-registered result for arithmetic/logic/compare ops.
- Shifts done serially, one bit per cycle, to save area on the MPW core; no barrel shifter.
- Valid/ready handshake on input and output so the pipeline can stall while a shift runs.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8)
- SHAMT_W, $clog2(XLEN), shift-amount width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_flush  in  1  synchronous abort of any in-flight op
- i_valid  in  1  operation request
- o_ready  out  1  block can accept a request this cycle
- i_alu_control  in  5  ALU control code from decoder
- i_operand_a  in  XLEN  rs1 / PC operand
- i_operand_b  in  XLEN  rs2 / immediate operand; [SHAMT_W-1:0] = shift amount
- o_valid  out  1  result available
- i_result_ready  in  1  consumer accepts result
- o_result  out  XLEN  operation result
- o_zero  out  1  o_result == 0, for BEQ/BNE

Behaviour:
- Interface: one clock i_clk; i_rst synchronous, active-high. Reset outputs: o_valid=0, o_ready=1, o_result=0, o_zero=1; FSM=IDLE; counter=0.
- Control codes:
  - ADD 00000: a+b
  - AND 00001, OR 00010, XOR 00011: bitwise
  - SLL 00100, SRL 00101, SRA 00110: serial shifts
  - SUB 10000: a-b
  - SLTU 11000: unsigned a<b -> {0..,1}
  - SLT 10111: signed a<b -> {0..,1}
  - Any other code executes as ADD.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; no overflow flag. SLT/SLTU zero-extend the 1-bit result to XLEN.
- FSM states IDLE, SHIFT, RESP.
- IDLE: o_ready=1, o_valid=0. On i_valid & o_ready, latch request.
  - Non-shift op: compute, register o_result, go RESP. Latency: o_valid high on the cycle after acceptance.
  - Shift with shamt==0: o_result=a, go RESP (latency 1).
  - Shift with shamt>0: load shift reg=a, counter=shamt, go SHIFT.
- SHIFT: o_ready=0. Each cycle, shift 1 bit and decrement counter.
  - SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates the original a[XLEN-1].
  - When counter reaches 0, copy the shift reg to o_result and go RESP.
  - Total latency from acceptance to o_valid = shamt+1 cycles (max XLEN).
- RESP: o_valid=1, o_ready=0. o_result and o_zero are held stable until i_result_ready=1, then go IDLE.
  - No back-to-back acceptance: the next request is accepted no earlier than the cycle after the handshake.
- o_zero is registered together with o_result and always equals (o_result==0).
- Inputs are sampled only at acceptance; changes on operand or control inputs during SHIFT or RESP have no effect.
- Priority: i_rst > i_flush > normal operation.
  - i_flush in any state: next cycle FSM=IDLE, o_valid=0, counter=0. o_result is unchanged.
  - i_flush together with i_valid in IDLE: the request is dropped.
  - A result in RESP that is flushed is never delivered.
- Reset mid-SHIFT or mid-RESP: next cycle equals full reset state.
- i_valid while o_ready=0 is ignored; the requester must hold it.

Test Plan:
- ADD a=0xFFFF_FFFF, b=1 -> 1 cycle later o_valid=1, o_result=0, o_zero=1. SUB a=5, b=7 -> 0xFFFF_FFFE, o_zero=0.
- SLT a=0xFFFF_FFFF, b=1 -> 1. SLTU with the same operands -> 0. Undefined code 01111, a=3, b=4 -> 7.
- SRA a=0x8000_0000, b=31 -> o_valid exactly 32 cycles after acceptance, result 0xFFFF_FFFF, o_ready=0 throughout. SRL with the same operands -> 0x0000_0001.
- SLL a=0x1, b=0 -> o_result=0x1 after 1 cycle. SLL a=0x1, b=0x24 (shamt=4) -> 0x10 after 5 cycles.
- Hold i_result_ready=0 for 10 cycles in RESP -> o_valid and o_result stable, o_ready=0. Raise it -> IDLE next cycle, o_ready=1.
- Mid-shift checks:
  - i_flush at cycle 3 of a 20-bit SLL -> o_valid never asserts, o_ready=1 next cycle; a following ADD 2+2 returns 4.
  - i_rst mid-shift -> reset values next cycle.
